// File: rtl/au_pkg.sv
// au_pkg: shared definitions for the arithmetic-unit result drain.
// Holds the drain FSM state encoding, the per-mode lane widths and the
// default arithmetic_unit latency.
package au_pkg;

  // Default number of cycles from operand capture to a valid product.
  localparam int AU_LAT_DEFAULT = 2;

  // Lane widths taken from the 32-bit product.
  // Mode 0: a single 24-bit lane in p[23:0].
  // Mode 1: two 16-bit lanes, p[15:0] and p[31:16].
  localparam int LANE_W_M0 = 24;
  localparam int LANE_W_M1 = 16;

  // Drain FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/au_align_pipe.sv
// au_align_pipe: fixed-depth register delay line with synchronous,
// active-high reset. Used to line up beat control with the product that
// leaves the arithmetic_unit DEPTH cycles later.
module au_align_pipe #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_delay
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift register; reset flushes everything in flight
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/au_result_drain.sv
// au_result_drain: accumulates arithmetic_unit products over a group of
// beats and holds the group result until the consumer takes it.
// Beat control (valid/mode/last) is delayed AU_LAT cycles so it lines up
// with p. Mode 0 accumulates one 24-bit lane, mode 1 two 16-bit lanes.
// ACC_W must be at least 24.
// Optional feature: define AU_DRAIN_SAT_EN for saturating lane adds;
// otherwise accumulation wraps modulo 2^ACC_W.
module au_result_drain
  import au_pkg::*;
#(
  parameter int AU_LAT   = AU_LAT_DEFAULT,
  parameter int BEAT_NUM = 16,
  parameter int ACC_W    = 40
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic                            in_mode,
  input  logic                            in_last,
  input  logic [31:0]                     p,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [ACC_W-1:0]         out_acc0,
  output logic signed [ACC_W-1:0]         out_acc1,
  output logic                            out_mode,
  output logic [$clog2(BEAT_NUM+1)-1:0]   out_cnt,
  output logic                            err
);

  localparam int                 CNT_W    = $clog2(BEAT_NUM + 1);
  localparam logic [CNT_W-1:0]   BEAT_MAX = CNT_W'(BEAT_NUM);
  localparam bit                 ONE_BEAT = (BEAT_NUM == 1);

`ifdef AU_DRAIN_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Signed add clamped to the ACC_W range on overflow.
  function automatic logic signed [ACC_W-1:0] lane_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W-1:0] sum;
    sum = a + b;
    if ((a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]))
      sum = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    return sum;
  endfunction
`else
  // Plain two's-complement add; overflow wraps modulo 2^ACC_W.
  function automatic logic signed [ACC_W-1:0] lane_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    return a + b;
  endfunction
`endif

  // ---- Stage p0: beat control realigned with the product ----
  logic [2:0] ctl_in;
  logic [2:0] ctl_p0;
  logic       vld_p0;
  logic       mode_p0;
  logic       last_p0;

  assign ctl_in = {in_valid, in_mode, in_last};

  au_align_pipe #(
    .WIDTH (3),
    .DEPTH (AU_LAT)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .din   (ctl_in),
    .dout  (ctl_p0)
  );

  assign vld_p0  = ctl_p0[2];
  assign mode_p0 = ctl_p0[1];
  assign last_p0 = ctl_p0[0];

  // Lane extraction from the product (signed views of the raw bits).
  logic signed [LANE_W_M0-1:0] m0_lane_p0;
  logic signed [LANE_W_M1-1:0] lo_lane_p0;
  logic signed [LANE_W_M1-1:0] hi_lane_p0;
  logic signed [ACC_W-1:0]     add0_p0;
  logic signed [ACC_W-1:0]     add1_p0;

  assign m0_lane_p0 = p[LANE_W_M0-1:0];
  assign lo_lane_p0 = p[LANE_W_M1-1:0];
  assign hi_lane_p0 = p[2*LANE_W_M1-1:LANE_W_M1];

  // Sign-extend the active lanes of the beat to accumulator width
  always_comb begin
    add0_p0 = '0;
    add1_p0 = '0;
    if (mode_p0) begin
      add0_p0 = ACC_W'(lo_lane_p0);
      add1_p0 = ACC_W'(hi_lane_p0);
    end else begin
      add0_p0 = ACC_W'(m0_lane_p0);
    end
  end

  // ---- Stage p1: group state and accumulators ----
  drain_state_e            state;
  logic                    mode_q;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    err_q;
  logic signed [ACC_W-1:0] acc0_p1;
  logic signed [ACC_W-1:0] acc1_p1;
  logic                    mode_mis_p0;
  logic                    load_p0;
  logic                    add_en_p0;

  assign cnt_inc     = cnt + CNT_W'(1);
  assign mode_mis_p0 = (mode_p0 != mode_q);
  // First beat of a group overwrites the accumulators; later matching
  // beats add into them. Beats in HOLD or with the wrong mode are dropped.
  assign load_p0     = (state == IDLE) && vld_p0;
  assign add_en_p0   = (state == ACCUM) && vld_p0 && !mode_mis_p0;

  // Group control: state transitions, beat count, latched mode, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vld_p0) begin
            mode_q <= mode_p0;
            cnt    <= CNT_W'(1);
            state  <= (last_p0 || ONE_BEAT) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (vld_p0) begin
            if (mode_mis_p0) begin
              err_q <= 1'b1;
            end else begin
              cnt <= cnt_inc;
              if (last_p0 || (cnt_inc == BEAT_MAX)) state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (vld_p0) err_q <= 1'b1;
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane accumulators: load on the group's first beat, add on later beats
  always_ff @(posedge clk) begin
    if (reset) begin
      acc0_p1 <= '0;
      acc1_p1 <= '0;
    end else if (load_p0) begin
      acc0_p1 <= add0_p0;
      acc1_p1 <= add1_p0;
    end else if (add_en_p0) begin
      acc0_p1 <= lane_add(acc0_p1, add0_p0);
      acc1_p1 <= lane_add(acc1_p1, add1_p0);
    end
  end

  assign out_valid = (state == HOLD);
  assign out_acc0  = acc0_p1;
  assign out_acc1  = acc1_p1;
  assign out_mode  = mode_q;
  assign out_cnt   = cnt;
  assign err       = err_q;

endmodule
